// File: rtl/rv_cell_v3.sv
// RootVoter cell v3: collects up to NUM_SETS datasets under a timeout, compares them
// pairwise one pair per cycle and reports the majority value with failure/timeout vectors.
`timescale 1ns/1ps
module rv_cell_v3 #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SETS   = 16,
  parameter int TMO_WIDTH  = 32,
  parameter int CW         = $clog2(NUM_SETS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           ack,
  input  logic [CW-1:0]                  used_sets,
  input  logic [CW-1:0]                  min_sets,
  input  logic [TMO_WIDTH-1:0]           timeout_cycles,
  input  logic [NUM_SETS*DATA_WIDTH-1:0] sets,
  input  logic [NUM_SETS-1:0]            valid,
  output logic                           busy,
  output logic                           ready,
  output logic                           cfg_err,
  output logic                           vote_ok,
  output logic [DATA_WIDTH-1:0]          voted_data,
  output logic [CW-1:0]                  voted_idx,
  output logic [NUM_SETS*CW-1:0]         match_cnt,
  output logic [NUM_SETS-1:0]            failvec,
  output logic [NUM_SETS-1:0]            timeout_vec,
  output logic [2:0]                     dbg_state
);
  localparam int IW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam logic [CW-1:0] NS_C = CW'(NUM_SETS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_VOTE   = 3'd2,
    S_SELECT = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    vote_ok_q, vote_ok_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q [NUM_SETS];
  logic [CW-1:0]           cnt_d [NUM_SETS];
  logic [NUM_SETS-1:0]     fail_q, fail_d;
  logic [NUM_SETS-1:0]     tvec_q, tvec_d;
  logic [NUM_SETS-1:0]     part_q, part_d;
  logic [CW-1:0]           used_q, used_d;
  logic [CW-1:0]           min_q, min_d;
  logic [CW-1:0]           i_q, i_d;
  logic [CW-1:0]           j_q, j_d;
  logic [TMO_WIDTH-1:0]    tmo_q, tmo_d;

  logic [DATA_WIDTH-1:0]   set_arr [NUM_SETS];
  logic [NUM_SETS-1:0]     mask, vmask;
  logic [IW-1:0]           ii, jj;
  logic                    cfg_ok, last_pair, pair_match, clear_res;
  logic                    best_found;
  logic [CW-1:0]           best_cnt, best_idx, sat;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_SETS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_SETS; k++) c = c + CW'(v[k]);
    return c;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_SETS; k++) begin
      set_arr[k] = sets[k*DATA_WIDTH +: DATA_WIDTH];
      mask[k]    = (CW'(k) < used_q);
    end
  end

  assign vmask      = valid & mask;
  assign ii         = i_q[IW-1:0];
  assign jj         = j_q[IW-1:0];
  assign sat        = used_q - CW'(1);
  assign last_pair  = (i_q == used_q - CW'(2)) && (j_q == used_q - CW'(1));
  assign pair_match = part_q[ii] && part_q[jj] && (set_arr[ii] == set_arr[jj]);
  assign cfg_ok     = (used_sets >= CW'(2)) && (used_sets <= NS_C) &&
                      (min_sets != '0) && (min_sets <= used_sets);

  // Highest match count among participants; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_found = 1'b0;
    best_cnt   = '0;
    best_idx   = '0;
    for (int k = 0; k < NUM_SETS; k++) begin
      if (part_q[k] && (!best_found || cnt_q[k] > best_cnt)) begin
        best_found = 1'b1;
        best_cnt   = cnt_q[k];
        best_idx   = CW'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    vote_ok_d = vote_ok_q;
    data_d    = data_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    tvec_d    = tvec_q;
    part_d    = part_q;
    used_d    = used_q;
    min_d     = min_q;
    i_d       = i_q;
    j_d       = j_q;
    tmo_d     = tmo_q;
    clear_res = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d   = S_WAIT;
            cfg_err_d = 1'b0;
            clear_res = 1'b1;
            part_d    = '0;
            used_d    = used_sets;
            min_d     = min_sets;
            tmo_d     = timeout_cycles;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (popcnt(vmask) == used_q) begin
          part_d  = vmask;
          state_d = S_VOTE;
          i_d     = '0;
          j_d     = CW'(1);
        end else if (tmo_q == '0) begin
          tvec_d = ~valid & mask;
          part_d = vmask;
          if (popcnt(vmask) >= min_q) begin
            state_d = S_VOTE;
            i_d     = '0;
            j_d     = CW'(1);
          end else begin
            state_d   = S_DONE;
            vote_ok_d = 1'b0;
            fail_d    = '0;
          end
        end else begin
          tmo_d = tmo_q - TMO_WIDTH'(1);
        end
      end
      S_VOTE: begin
        if (pair_match) begin
          if (cnt_q[ii] != sat) cnt_d[ii] = cnt_q[ii] + CW'(1);
          if (cnt_q[jj] != sat) cnt_d[jj] = cnt_q[jj] + CW'(1);
        end
        if (last_pair) begin
          state_d = S_SELECT;
        end else if (j_q == used_q - CW'(1)) begin
          i_d = i_q + CW'(1);
          j_d = i_q + CW'(2);
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      S_SELECT: begin
        idx_d     = best_idx;
        data_d    = set_arr[best_idx[IW-1:0]];
        vote_ok_d = ((best_cnt + CW'(1)) >= min_q);
        for (int k = 0; k < NUM_SETS; k++)
          fail_d[k] = part_q[k] && ((cnt_q[k] + CW'(1)) < min_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      clear_res = 1'b1;
    end

    if (clear_res) begin
      vote_ok_d = 1'b0;
      data_d    = '0;
      idx_d     = '0;
      fail_d    = '0;
      tvec_d    = '0;
      for (int k = 0; k < NUM_SETS; k++) cnt_d[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cfg_err_q <= 1'b0;
      vote_ok_q <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
      fail_q    <= '0;
      tvec_q    <= '0;
      part_q    <= '0;
      used_q    <= '0;
      min_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      tmo_q     <= '0;
      for (int k = 0; k < NUM_SETS; k++) cnt_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      vote_ok_q <= vote_ok_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      fail_q    <= fail_d;
      tvec_q    <= tvec_d;
      part_q    <= part_d;
      used_q    <= used_d;
      min_q     <= min_d;
      i_q       <= i_d;
      j_q       <= j_d;
      tmo_q     <= tmo_d;
      for (int k = 0; k < NUM_SETS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SETS; k++) match_cnt[k*CW +: CW] = cnt_q[k];
  end

  assign busy        = (state_q == S_WAIT) || (state_q == S_VOTE) || (state_q == S_SELECT);
  assign ready       = (state_q == S_DONE);
  assign cfg_err     = cfg_err_q;
  assign vote_ok     = vote_ok_q;
  assign voted_data  = data_q;
  assign voted_idx   = idx_q;
  assign failvec     = fail_q;
  assign timeout_vec = tvec_q;
  assign dbg_state   = state_q;
endmodule

// File: doc/rv_cell_v3.md
Name: rv_cell_v3

Overview:
- Third-generation RootVoter cell: parametrised N-modular voter for multicore lockstep/redundant execution.
- Collects up to NUM_SETS result datasets under a timeout, compares them pairwise one pair per cycle, and counts matches per dataset.
- Selects and outputs the majority value, plus failure and timeout vectors.
- Sits behind the RootVoter APB register block, which drives the start/config/ack fields and reads the results.

Parameters:
- DATA_WIDTH, 64, width of each dataset.
- NUM_SETS, 16, maximum datasets (2..16).
- TMO_WIDTH, 32, timeout counter width.
- CW, $clog2(NUM_SETS+1), width of count and index fields.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to arm the voter; honoured only in IDLE.
- abort  in  1  abandon current vote; return to IDLE.
- ack  in  1  consume result; DONE -> IDLE.
- used_sets  in  CW  number of datasets expected; sampled at start.
- min_sets  in  CW  quorum needed to vote; sampled at start.
- timeout_cycles  in  TMO_WIDTH  wait budget; sampled at start.
- sets  in  NUM_SETS*DATA_WIDTH  flattened datasets; set k at [k*DATA_WIDTH +: DATA_WIDTH].
- valid  in  NUM_SETS  per-dataset loaded flags.
- busy  out  1  high in WAIT, VOTE, SELECT.
- ready  out  1  high in DONE.
- cfg_err  out  1  start rejected due to bad config; sticky until next accepted start.
- vote_ok  out  1  majority reached quorum.
- voted_data  out  DATA_WIDTH  majority dataset value.
- voted_idx  out  CW  index of the majority dataset.
- match_cnt  out  NUM_SETS*CW  per-dataset count of other datasets that match it.
- failvec  out  NUM_SETS  participating sets with match_cnt+1 < min_sets.
- timeout_vec  out  NUM_SETS  sets in range that were not valid at expiry.

Behaviour:
- Reset: state IDLE. All outputs, the counter and internal snapshots are 0.
- Config check at start (registered): config is OK when 2 <= used_sets <= NUM_SETS and 1 <= min_sets <= used_sets.
  - Bad config: remain IDLE, set cfg_err the next cycle.
  - Good config: clear cfg_err, all result outputs and match_cnt; load counter = timeout_cycles; go to WAIT.
- mask[k] = (k < used_sets_reg). Valid bits outside the mask are ignored everywhere.
- WAIT, evaluated each cycle:
  - If popcount(valid & mask) == used_sets: snapshot part = valid & mask; go to VOTE.
  - Else if counter == 0 (expired): timeout_vec = ~valid & mask; part = valid & mask.
    - popcount(part) >= min_sets -> VOTE.
    - Otherwise -> DONE with vote_ok = 0 and failvec = 0.
  - Otherwise counter decrements.
  - All-valid takes priority over expiry in the same cycle. timeout_cycles = T expires on WAIT cycle T+1.
- VOTE:
  - Pair iterator (i,j), i<j<used_sets_reg, in row-major order (0,1),(0,2)...(used-2,used-1).
  - Exactly one pair per cycle, so VOTE lasts used*(used-1)/2 cycles regardless of part.
  - If part[i] && part[j] && sets[i] == sets[j]: increment match_cnt[i] and match_cnt[j]. Counts saturate at used_sets-1.
  - After the last pair -> SELECT.
- SELECT, 1 cycle:
  - voted_idx = participating index with the maximum match_cnt; ties go to the lowest index.
  - voted_data = sets[voted_idx]; vote_ok = (max+1 >= min_sets_reg); failvec = part & {match_cnt[k]+1 < min_sets_reg}.
  - Go to DONE.
- DONE: ready = 1 and all results are held. ack -> IDLE on the next cycle, and ready drops. Results stay readable in IDLE until the next accepted start.
- Datasets must remain stable from valid assertion until SELECT completes. The block does not copy data.
- start outside IDLE is ignored. abort in any non-IDLE state -> IDLE next cycle, clearing results and timeout_vec. abort has priority over ack and all other transitions.
- reset mid-operation -> IDLE with all outputs 0 on the next edge.

Test Plan:
- used=3, min=2, T=100, all three valid with equal data 0xA5 by cycle 5 -> VOTE lasts 3 cycles; match_cnt = {2,2,2}; vote_ok = 1; voted_idx = 0; failvec = 0; ready 5 cycles after WAIT exit.
- used=4, min=3, sets {7,7,9,7} all valid -> match_cnt = {2,2,0,2}; voted_data = 7; voted_idx = 0; failvec = 0b0100; vote_ok = 1.
- used=5, min=3, T=10, only sets 0,1,3 valid with equal data -> expiry on WAIT cycle 11; timeout_vec = 0b10100; VOTE lasts 10 cycles; vote_ok = 1; failvec = 0.
- used=4, min=3, T=4, only set 2 valid -> DONE without VOTE; timeout_vec = 0b1011; vote_ok = 0; failvec = 0.
- used=1 or min=0 or used=NUM_SETS+1 at start -> cfg_err = 1, busy stays 0. A following good start clears cfg_err.
- Mid-VOTE abort, then start while busy (ignored), then reset during WAIT -> IDLE with all outputs 0; a subsequent normal vote produces correct results.
